sub_seq_pipe: RTL and testbench
===============================

// Module: sub_seq_pipe
// PURPOSE
//   Elastic pipelined unsigned subtractor, diff = in1 - in2. Companion to the team's
//   pipelined segmented adder.
//   Borrow ripples across three registered segments: [7:0] -> [15:8] -> [W-1:16].
//   Sits in the datapath between a valid/ready producer and a valid/ready consumer.
// PARAMETERS
//   WIDTH     32   operand/result width; legal range 17..64; top segment = WIDTH-16 bits
// PORTS
//   clk         in   1      rising-edge clock, single clock domain
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      operand pair present
//   in_ready    out  1      block can accept operands this cycle
//   in1         in   WIDTH  minuend
//   in2         in   WIDTH  subtrahend
//   out_valid   out  1      result present
//   out_ready   in   1      consumer takes result this cycle
//   diff        out  WIDTH  in1 - in2 mod 2^WIDTH
//   borrow_out  out  1      1 iff in1 < in2 (unsigned)
//   flags       out  3      {ovf,neg,zero}; present only with SUB_SEQ_FLAGS_EN
// BEHAVIOUR
//   - Reset (async assert, sync release): every valid bit 0; diff, borrow_out and flags are 0.
//   - Transfers: input on in_valid&in_ready; output on out_valid&out_ready, both at posedge clk.
//   - Stages:
//     S1 registers {in1,in2} and computes seg0 diff/borrow0 from them.
//     S2 computes seg1 with borrow0.
//     S3 computes seg2 with borrow1 and drives the output registers.
//   - Per segment: {b_out, d} = {1'b0,a} - {1'b0,b} - b_in. The extra top bit is the borrow.
//   - Latency: operands accepted at edge k appear with out_valid=1 after edge k+3.
//   - Throughput: one result per cycle while out_ready=1.
//   - Stall: en3 = !out_valid | out_ready; en_i = !v_i | en_{i+1}; in_ready = en1.
//     in_ready is combinational from out_ready; there is no in_valid -> in_ready path.
//   - A stalled stage holds its data and valid bit unchanged.
//   - While out_valid=1 and out_ready=0, diff, borrow_out and flags stay stable.
//   - Bubbles: an empty stage is filled when its predecessor is valid, even if the output is stalled.
//     Four operand pairs fit in the pipe when the output is fully backpressured.
//   - Simultaneous accept and emit in the same cycle: both happen, and no entry is lost or duplicated.
//   - Reset mid-operation: all in-flight entries are discarded; out_valid=0 in the next cycle.
//   - Ordering: strictly FIFO, no reordering or dropping.
//   - Wrap: 0 - 1 gives diff = all ones and borrow_out = 1.
// CONFIGURATION
//   SUB_SEQ_FLAGS_EN defined:
//     - flags is registered alongside diff.
//     - zero = (diff == 0); neg = diff[WIDTH-1].
//     - ovf = signed overflow = (in1[MSB] ^ in2[MSB]) & (in1[MSB] ^ diff[MSB]).
//     - Operand MSBs are carried through the pipe for ovf.
//   SUB_SEQ_FLAGS_EN undefined: flags port and MSB pipeline regs are absent; all other timing is identical.
// STRUCTURE
//   sub_seq_pkg:
//     - localparams SEG0_W=8, SEG1_W=8, SEG0_LSB=0, SEG1_LSB=8, SEG2_LSB=16.
//     - Flag bit indices FLAG_ZERO=0, FLAG_NEG=1, FLAG_OVF=2.
//   Sub-module sub_seq_seg #(W):
//     - Combinational segment a - b - b_in giving {b_out, d}.
//     - Instantiated three times; stage registers live in sub_seq_pipe.
// TESTING
//   1 Reset
//     - Stimulus: assert rst_n=0 with in_valid=1.
//     - Required: out_valid=0, diff=0, borrow_out=0; after release, in_ready=1.
//   2 Basic
//     - Stimulus: 0x0000_0100 - 0x0000_0001 with out_ready=1.
//     - Required: diff=0x0000_00FF, borrow_out=0, out_valid exactly 3 cycles after accept.
//   3 Borrow chain
//     - Stimulus: 0x0001_0000 - 0x0000_0001.
//     - Required: diff=0x0000_FFFF, borrow_out=0.
//     - Stimulus: 0 - 1.
//     - Required: diff=0xFFFF_FFFF, borrow_out=1.
//   4 Backpressure
//     - Stimulus: out_ready=0, stream 6 values.
//     - Required: 4 accepted, then in_ready=0; hold out_ready=0 10 cycles -> diff stable.
//     - Then: release -> 6 results in order, one per cycle.
//   5 Mid-flight reset
//     - Stimulus: 3 entries in flight, pulse rst_n low between edges.
//     - Required: out_valid=0; no stale result after release.
//   6 Flags (SUB_SEQ_FLAGS_EN)
//     - 0x8000_0000 - 1 -> flags=3'b100.
//     - 5 - 5 -> flags=3'b001.
//     - 1 - 2 -> flags=3'b010.

Source files
------------

// File: rtl/sub_seq_pkg.sv
// Shared segment geometry and flag bit positions for the pipelined subtractor.
package sub_seq_pkg;
    localparam int SEG0_W   = 8;
    localparam int SEG1_W   = 8;
    localparam int SEG0_LSB = 0;
    localparam int SEG1_LSB = 8;
    localparam int SEG2_LSB = 16;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 2;
endpackage

// File: rtl/sub_seq_seg.sv
// Combinational subtract segment: {b_out, d} = a - b - b_in.
module sub_seq_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         b_in_i,
    output logic [W-1:0] d_o,
    output logic         b_out_o
);
    assign {b_out_o, d_o} = {1'b0, a_i} - {1'b0, b_i} - (W+1)'(b_in_i);
endmodule

// File: rtl/sub_seq_pipe.sv
// Elastic 3-segment borrow-ripple subtractor with valid/ready on both sides.
// Optional {ovf,neg,zero} flags output when SUB_SEQ_FLAGS_EN is defined.
module sub_seq_pipe
    import sub_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_SEQ_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);
    localparam int SEG2_W = WIDTH - SEG2_LSB;

    // vld_q[0]=operand regs, [1]=seg0 done, [2]=seg1 done, [3]=output regs
    logic [3:0] vld_q;
    logic [3:0] en;

    logic [WIDTH-1:0]        s1_a_q, s1_b_q;
    logic [WIDTH-1:SEG1_LSB] s2_a_q, s2_b_q;
    logic [SEG0_W-1:0]       s2_d_q;
    logic                    s2_bw_q;
    logic [WIDTH-1:SEG2_LSB] s3_a_q, s3_b_q;
    logic [SEG2_LSB-1:0]     s3_d_q;
    logic                    s3_bw_q;
    logic [WIDTH-1:0]        diff_q;
    logic                    borrow_q;

    logic [SEG0_W-1:0] seg0_d;
    logic [SEG1_W-1:0] seg1_d;
    logic [SEG2_W-1:0] seg2_d;
    logic              seg0_bo, seg1_bo, seg2_bo;
    logic [WIDTH-1:0]  diff_d;

    always_comb begin
        en    = '0;
        en[3] = !vld_q[3] | out_ready;
        for (int i = 2; i >= 0; i--)
            en[i] = !vld_q[i] | en[i+1];
    end

    assign in_ready   = en[0];
    assign out_valid  = vld_q[3];
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

    sub_seq_seg #(.W(SEG0_W)) u_seg0 (
        .a_i(s1_a_q[SEG0_LSB +: SEG0_W]), .b_i(s1_b_q[SEG0_LSB +: SEG0_W]),
        .b_in_i(1'b0), .d_o(seg0_d), .b_out_o(seg0_bo)
    );
    sub_seq_seg #(.W(SEG1_W)) u_seg1 (
        .a_i(s2_a_q[SEG1_LSB +: SEG1_W]), .b_i(s2_b_q[SEG1_LSB +: SEG1_W]),
        .b_in_i(s2_bw_q), .d_o(seg1_d), .b_out_o(seg1_bo)
    );
    sub_seq_seg #(.W(SEG2_W)) u_seg2 (
        .a_i(s3_a_q), .b_i(s3_b_q),
        .b_in_i(s3_bw_q), .d_o(seg2_d), .b_out_o(seg2_bo)
    );

    assign diff_d = {seg2_d, s3_d_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            if (en[0]) vld_q[0] <= in_valid;
            for (int i = 1; i < 4; i++)
                if (en[i]) vld_q[i] <= vld_q[i-1];
        end
    end

    // Data regs only load on a real entry so a bubble never disturbs held values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_a_q   <= '0;
            s2_b_q   <= '0;
            s2_d_q   <= '0;
            s2_bw_q  <= 1'b0;
            s3_a_q   <= '0;
            s3_b_q   <= '0;
            s3_d_q   <= '0;
            s3_bw_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            if (en[0] && in_valid) begin
                s1_a_q <= in1;
                s1_b_q <= in2;
            end
            if (en[1] && vld_q[0]) begin
                s2_a_q  <= s1_a_q[WIDTH-1:SEG1_LSB];
                s2_b_q  <= s1_b_q[WIDTH-1:SEG1_LSB];
                s2_d_q  <= seg0_d;
                s2_bw_q <= seg0_bo;
            end
            if (en[2] && vld_q[1]) begin
                s3_a_q  <= s2_a_q[WIDTH-1:SEG2_LSB];
                s3_b_q  <= s2_b_q[WIDTH-1:SEG2_LSB];
                s3_d_q  <= {seg1_d, s2_d_q};
                s3_bw_q <= seg1_bo;
            end
            if (en[3] && vld_q[2]) begin
                diff_q   <= diff_d;
                borrow_q <= seg2_bo;
            end
        end
    end

`ifdef SUB_SEQ_FLAGS_EN
    logic [2:0] flags_q;
    logic [2:0] flags_d;

    // Operand MSBs ride along in the top-segment operand regs.
    always_comb begin
        flags_d            = '0;
        flags_d[FLAG_ZERO] = (diff_d == '0);
        flags_d[FLAG_NEG]  = diff_d[WIDTH-1];
        flags_d[FLAG_OVF]  = (s3_a_q[WIDTH-1] ^ s3_b_q[WIDTH-1]) &
                             (s3_a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= '0;
        else if (en[3] && vld_q[2])
            flags_q <= flags_d;
    end

    assign flags = flags_q;
`endif
endmodule

// File: tb/tb_sub_seq_pipe.sv
// Directed self-checking bench for sub_seq_pipe (WIDTH=32); flag checks under SUB_SEQ_FLAGS_EN.
module tb_sub_seq_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1, in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
`ifdef SUB_SEQ_FLAGS_EN
    logic [2:0]  flags;
`endif

    int total = 0;
    int bad   = 0;

    sub_seq_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out)
`ifdef SUB_SEQ_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one pair with out_ready=1 and check the result when it emerges.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ed, input logic eb, input logic [2:0] ef);
        in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) tick();
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_diff"}, 64'(diff), 64'(ed));
        chk({tag, "_brw"}, 64'(borrow_out), 64'(eb));
`ifdef SUB_SEQ_FLAGS_EN
        chk({tag, "_flags"}, 64'(flags), 64'(ef));
`else
        if (ef != 3'b000 && ed == 32'hdead_beef) $display("unused");
`endif
        tick();
    endtask

    logic [31:0] va [6] = '{32'd10, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h00FF_0000};
    logic [31:0] vb [6] = '{32'd3,  32'h1111_1111, 32'h10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_FF00};
    logic [31:0] vd [6] = '{32'd7,  32'h0123_4567, 32'hFFFF_FFF0, 32'h0, 32'h1, 32'h00FE_0100};
    logic        vbw [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int idx, ridx, acc, first_c, last_c;
        logic [31:0] held;

        // 1 reset with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; in1 = 32'h55; in2 = 32'h11; out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow", 64'(borrow_out), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // 2 basic, exact latency
        in1 = 32'h0000_0100; in2 = 32'h0000_0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_k0", 64'(out_valid), 64'd0);
        tick();
        chk("lat_k1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_k2", 64'(out_valid), 64'd0);
        tick();
        chk("lat_k3", 64'(out_valid), 64'd1);
        chk("basic_diff", 64'(diff), 64'h0000_00FF);
        chk("basic_brw", 64'(borrow_out), 64'd0);
        tick();
        chk("basic_drain", 64'(out_valid), 64'd0);

        // 3 borrow chain
        send_one("chain16", 32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 3'b000);
        send_one("wrap", 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 3'b010);

        // 4 backpressure: only four fit
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6);
            in1 = va[idx % 6]; in2 = vb[idx % 6];
            #1;
            acc = int'(in_valid && in_ready);
            tick();
            if (acc != 0) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd4);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_vld", 64'(out_valid), 64'd1);
        held = diff;
        chk("bp_head_diff", 64'(held), 64'(vd[0]));
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            assert (diff === held && out_valid === 1'b1) else begin
                bad++;
                $error("FAIL bp_stable observed=%0h expected=%0h", diff, held);
            end
        end

        out_ready = 1'b1;
        ridx = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 30 && ridx < 6; c++) begin
            if (out_valid) begin
                chk("bp_order_diff", 64'(diff), 64'(vd[ridx]));
                chk("bp_order_brw", 64'(borrow_out), 64'(vbw[ridx]));
                if (first_c < 0) first_c = c;
                last_c = c;
                ridx++;
            end
            in_valid = (idx < 6);
            in1 = va[idx % 6]; in2 = vb[idx % 6];
            #1;
            acc = int'(in_valid && in_ready);
            tick();
            if (acc != 0) idx++;
        end
        in_valid = 1'b0;
        chk("bp_count", 64'(ridx), 64'd6);
        chk("bp_back_to_back", 64'(last_c - first_c), 64'd5);

        // 5 mid-flight reset
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in1 = 32'd100 + 32'(c); in2 = 32'd1;
            tick();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(out_valid), 64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid) acc++;
        end
        chk("mid_rst_stale", 64'(acc), 64'd0);

`ifdef SUB_SEQ_FLAGS_EN
        // 6 flags
        send_one("fl_ovf", 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 3'b100);
        send_one("fl_zero", 32'd5, 32'd5, 32'h0, 1'b0, 3'b001);
        send_one("fl_neg", 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 3'b010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
